// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: access sizes and bus FSM states.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane logic: store byte enables / data replication,
// load lane extraction with sign or zero extension, misalignment detect.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = load_raw[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];

  always_comb begin
    be         = 4'b0000;
    wdata      = '0;
    load_data  = '0;
    misaligned = 1'b0;
    case (size)
      MEM_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      MEM_H: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      // the reserved encoding behaves exactly like a word access
      MEM_W, MEM_SIZE_RSVD: begin
        misaligned = (addr_lo != 2'b00);
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = load_raw;
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = load_raw;
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: E->M register, variable-latency data-memory
// handshake with optional timeout, load formatting and front-end stall.
module memory_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_e,
  input  logic        mem_to_reg_e,
  input  logic        mem_write_e,
  input  logic [1:0]  mem_size_e,
  input  logic        mem_unsigned_e,
  input  logic [31:0] alu_out_e,
  input  logic [31:0] write_data_e,
  input  logic [4:0]  write_reg_e,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_m,
  output logic        reg_write_m,
  output logic        mem_to_reg_m,
  output logic [31:0] alu_out_m,
  output logic [31:0] read_data_m,
  output logic [4:0]  write_reg_m,
  output logic        addr_err_m,
  output logic        bus_err_m
);

  localparam bit              TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic        reg_write_p0, mem_to_reg_p0, mem_write_p0, mem_unsigned_p0;
  logic [1:0]  mem_size_p0;
  logic [31:0] alu_out_p0, write_data_p0;
  logic [4:0]  write_reg_p0;

  mem_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             timeout_hit;
  logic             access, misaligned_raw, misaligned, mem_op;
  logic [31:0]      load_data;

  // E -> M register; held while an access is outstanding so the bus stays stable
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_p0    <= 1'b0;
      mem_to_reg_p0   <= 1'b0;
      mem_write_p0    <= 1'b0;
      mem_size_p0     <= 2'b00;
      mem_unsigned_p0 <= 1'b0;
      alu_out_p0      <= '0;
      write_data_p0   <= '0;
      write_reg_p0    <= '0;
    end else if (!stall_m) begin
      reg_write_p0    <= reg_write_e;
      mem_to_reg_p0   <= mem_to_reg_e;
      mem_write_p0    <= mem_write_e;
      mem_size_p0     <= mem_size_e;
      mem_unsigned_p0 <= mem_unsigned_e;
      alu_out_p0      <= alu_out_e;
      write_data_p0   <= write_data_e;
      write_reg_p0    <= write_reg_e;
    end
  end

  mem_lane_fmt u_lane_fmt (
    .size        (mem_size_p0),
    .is_unsigned (mem_unsigned_p0),
    .addr_lo     (alu_out_p0[1:0]),
    .store_data  (write_data_p0),
    .load_raw    (dmem_rdata),
    .be          (dmem_be),
    .wdata       (dmem_wdata),
    .load_data   (load_data),
    .misaligned  (misaligned_raw)
  );

  assign access     = mem_to_reg_p0 | mem_write_p0;
  assign misaligned = access & misaligned_raw;
  assign mem_op     = access & ~misaligned_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    dmem_req    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = mem_op;
        if (mem_op && !dmem_ack) begin
          state_next = WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_next = IDLE;
        end else if (TIMEOUT_EN && (cnt == TIMEOUT_VAL)) begin
          // abandon the access; write-back sees it as a completed load of 0
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dmem_we      = mem_write_p0;
  assign dmem_addr    = {alu_out_p0[31:2], 2'b00};
  assign stall_m      = dmem_req & ~dmem_ack & ~timeout_hit;
  assign bus_err_m    = timeout_hit;
  assign addr_err_m   = misaligned;
  assign reg_write_m  = reg_write_p0 & ~stall_m & ~misaligned;
  assign mem_to_reg_m = mem_to_reg_p0;
  assign alu_out_m    = alu_out_p0;
  assign write_reg_m  = write_reg_p0;
  assign read_data_m  = (mem_to_reg_p0 & ~misaligned & ~timeout_hit) ? load_data : '0;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: zero-wait and waited loads, sub-word
// formatting, stores, misalignment, timeout and reset during a wait.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, mem_unsigned_e;
  logic [1:0]  mem_size_e;
  logic [31:0] alu_out_e, write_data_e;
  logic [4:0]  write_reg_e;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_m, reg_write_m, mem_to_reg_m, addr_err_m, bus_err_m;
  logic [31:0] alu_out_m, read_data_m;
  logic [4:0]  write_reg_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  memory_access #(.TIMEOUT_CYCLES(4), .CNT_W(9)) dut (
    .clk            (clk),
    .rst            (rst),
    .reg_write_e    (reg_write_e),
    .mem_to_reg_e   (mem_to_reg_e),
    .mem_write_e    (mem_write_e),
    .mem_size_e     (mem_size_e),
    .mem_unsigned_e (mem_unsigned_e),
    .alu_out_e      (alu_out_e),
    .write_data_e   (write_data_e),
    .write_reg_e    (write_reg_e),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .stall_m        (stall_m),
    .reg_write_m    (reg_write_m),
    .mem_to_reg_m   (mem_to_reg_m),
    .alu_out_m      (alu_out_m),
    .read_data_m    (read_data_m),
    .write_reg_m    (write_reg_m),
    .addr_err_m     (addr_err_m),
    .bus_err_m      (bus_err_m)
  );

  task automatic drive_e(input logic rw, input logic m2r, input logic mw, input logic [1:0] sz,
                         input logic uns, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr);
    reg_write_e = rw; mem_to_reg_e = m2r; mem_write_e = mw; mem_size_e = sz;
    mem_unsigned_e = uns; alu_out_e = alu; write_data_e = wd; write_reg_e = wr;
  endtask

  task automatic drive_nop();
    drive_e(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive_e(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h55, 5'd5);
    cycle(); cycle();
    @(negedge clk);
    n_tests++; if ({reg_write_m, mem_to_reg_m, dmem_req, stall_m, addr_err_m, bus_err_m} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b want 000000", {reg_write_m, mem_to_reg_m, dmem_req, stall_m, addr_err_m, bus_err_m}); end
    n_tests++; if ({alu_out_m, write_reg_m} !== 37'h0) begin
      n_fail++; $display("FAIL reset_data got alu=%h wr=%0d want 0", alu_out_m, write_reg_m); end
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_lw_zero_wait();
    drive_e(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5);
    cycle();
    drive_nop(); dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++; if ({dmem_req, dmem_we, stall_m, reg_write_m, mem_to_reg_m} !== 5'b10011) begin
      n_fail++; $display("FAIL lw_ctl got %b want 10011", {dmem_req, dmem_we, stall_m, reg_write_m, mem_to_reg_m}); end
    n_tests++; if (dmem_be !== 4'b1111) begin n_fail++; $display("FAIL lw_be got %b want 1111", dmem_be); end
    n_tests++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr got %h want 00000100", dmem_addr); end
    n_tests++; if (read_data_m !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %h want deadbeef", read_data_m); end
    n_tests++; if (write_reg_m !== 5'd5) begin n_fail++; $display("FAIL lw_wreg got %0d want 5", write_reg_m); end
    cycle();
    dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++; if ({dmem_req, stall_m} !== 2'b00) begin n_fail++; $display("FAIL lw_after got %b want 00", {dmem_req, stall_m}); end
    cycle();
  endtask

  task automatic test_lb_wait();
    drive_e(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd7);
    cycle();
    drive_nop(); dmem_ack = 1'b0; dmem_rdata = 32'h80112233;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if ({dmem_req, stall_m, reg_write_m, bus_err_m} !== 4'b1100) begin
        n_fail++; $display("FAIL lb_wait%0d got %b want 1100", i, {dmem_req, stall_m, reg_write_m, bus_err_m}); end
      n_tests++; if ({dmem_addr, dmem_be} !== {32'h100, 4'b1000}) begin
        n_fail++; $display("FAIL lb_bus%0d got %h/%b want 00000100/1000", i, dmem_addr, dmem_be); end
      n_tests++; if (alu_out_m !== 32'h103) begin n_fail++; $display("FAIL lb_hold%0d got %h want 00000103", i, alu_out_m); end
      cycle();
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    n_tests++; if ({stall_m, reg_write_m} !== 2'b01) begin n_fail++; $display("FAIL lb_ack got %b want 01", {stall_m, reg_write_m}); end
    n_tests++; if (read_data_m !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata got %h want ffffff80", read_data_m); end
    cycle();
    dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++; if ({dmem_req, stall_m, alu_out_m} !== {2'b00, 32'h0}) begin
      n_fail++; $display("FAIL lb_after got req=%b stall=%b alu=%h want 0 0 0", dmem_req, stall_m, alu_out_m); end
    cycle();
  endtask

  task automatic test_back_to_back();
    drive_e(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd8);
    cycle();
    drive_e(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF, 5'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h9ABC1234;
    @(negedge clk);
    n_tests++; if (read_data_m !== 32'h00009ABC) begin n_fail++; $display("FAIL lhu_rdata got %h want 00009abc", read_data_m); end
    n_tests++; if ({dmem_be, reg_write_m, stall_m} !== 6'b1100_1_0) begin
      n_fail++; $display("FAIL lhu_ctl got %b want 110010", {dmem_be, reg_write_m, stall_m}); end
    cycle();
    drive_nop();
    @(negedge clk);
    n_tests++; if ({dmem_req, dmem_we, dmem_be} !== 6'b11_1100) begin
      n_fail++; $display("FAIL sh_ctl got %b want 111100", {dmem_req, dmem_we, dmem_be}); end
    n_tests++; if (dmem_wdata !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_wdata got %h want beefbeef", dmem_wdata); end
    n_tests++; if ({reg_write_m, read_data_m} !== 33'h0) begin
      n_fail++; $display("FAIL sh_wb got rw=%b rd=%h want 0 0", reg_write_m, read_data_m); end
    cycle();
    dmem_ack = 1'b0;
  endtask

  task automatic test_sub_word();
    // sb at byte 1: enable lane 1, replicate the low byte
    drive_e(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h123456A5, 5'd0);
    cycle();
    drive_nop(); dmem_ack = 1'b1;
    @(negedge clk);
    n_tests++; if ({dmem_be, dmem_wdata} !== {4'b0010, 32'hA5A5A5A5}) begin
      n_fail++; $display("FAIL sb_bus got %b/%h want 0010/a5a5a5a5", dmem_be, dmem_wdata); end
    cycle();
    drive_e(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 5'd9);
    cycle();
    drive_nop(); dmem_rdata = 32'h00008001;
    @(negedge clk);
    n_tests++; if (read_data_m !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_rdata got %h want ffff8001", read_data_m); end
    cycle();
    drive_e(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 5'd9);
    cycle();
    drive_nop(); dmem_rdata = 32'h0000F000;
    @(negedge clk);
    n_tests++; if (read_data_m !== 32'h000000F0) begin n_fail++; $display("FAIL lbu_rdata got %h want 000000f0", read_data_m); end
    cycle();
    dmem_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    drive_e(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd3);
    cycle();
    drive_e(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd4);
    dmem_ack = 1'b0; dmem_rdata = 32'h11111111;
    @(negedge clk);
    n_tests++; if ({addr_err_m, dmem_req, stall_m, reg_write_m} !== 4'b1000) begin
      n_fail++; $display("FAIL mis_lw got %b want 1000", {addr_err_m, dmem_req, stall_m, reg_write_m}); end
    cycle();
    drive_nop();
    @(negedge clk);
    n_tests++; if ({addr_err_m, dmem_req, stall_m, reg_write_m} !== 4'b0001) begin
      n_fail++; $display("FAIL alu_odd got %b want 0001", {addr_err_m, dmem_req, stall_m, reg_write_m}); end
    n_tests++; if ({alu_out_m, read_data_m, write_reg_m} !== {32'h101, 32'h0, 5'd4}) begin
      n_fail++; $display("FAIL alu_odd_data got %h/%h/%0d want 00000101/0/4", alu_out_m, read_data_m, write_reg_m); end
    cycle();
  endtask

  task automatic test_timeout();
    drive_e(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5'd6);
    cycle();
    drive_nop(); dmem_ack = 1'b0; dmem_rdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if ({dmem_req, stall_m, bus_err_m, reg_write_m} !== 4'b1100) begin
        n_fail++; $display("FAIL to_wait%0d got %b want 1100", i, {dmem_req, stall_m, bus_err_m, reg_write_m}); end
      cycle();
    end
    @(negedge clk);
    n_tests++; if ({stall_m, bus_err_m, reg_write_m} !== 3'b011) begin
      n_fail++; $display("FAIL to_hit got %b want 011", {stall_m, bus_err_m, reg_write_m}); end
    n_tests++; if (read_data_m !== 32'h0) begin n_fail++; $display("FAIL to_rdata got %h want 0", read_data_m); end
    cycle();
    @(negedge clk);
    n_tests++; if ({dmem_req, stall_m, bus_err_m} !== 3'b000) begin
      n_fail++; $display("FAIL to_after got %b want 000", {dmem_req, stall_m, bus_err_m}); end
    cycle();
  endtask

  task automatic test_reset_in_wait();
    drive_e(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd9);
    cycle();
    drive_nop(); dmem_ack = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if ({dmem_req, stall_m} !== 2'b11) begin n_fail++; $display("FAIL rw_pre got %b want 11", {dmem_req, stall_m}); end
    cycle();
    @(negedge clk);
    n_tests++; if ({dmem_req, stall_m, reg_write_m, mem_to_reg_m, bus_err_m, addr_err_m} !== 6'b0) begin
      n_fail++; $display("FAIL rw_ctl got %b want 000000", {dmem_req, stall_m, reg_write_m, mem_to_reg_m, bus_err_m, addr_err_m}); end
    n_tests++; if ({alu_out_m, write_reg_m} !== 37'h0) begin
      n_fail++; $display("FAIL rw_data got alu=%h wr=%0d want 0", alu_out_m, write_reg_m); end
    rst = 1'b0;
    drive_e(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 5'd3);
    cycle();
    drive_nop(); dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    n_tests++; if ({dmem_req, stall_m, reg_write_m} !== 3'b101) begin
      n_fail++; $display("FAIL rw_lw got %b want 101", {dmem_req, stall_m, reg_write_m}); end
    n_tests++; if ({dmem_addr, read_data_m, write_reg_m} !== {32'h104, 32'hCAFEF00D, 5'd3}) begin
      n_fail++; $display("FAIL rw_lw_data got %h/%h/%0d want 00000104/cafef00d/3", dmem_addr, read_data_m, write_reg_m); end
    cycle();
    dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_lb_wait();
    test_back_to_back();
    test_sub_word();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline stage between execute and write-back.
- Holds the E->M pipeline register and drives the data-memory bus through a variable-latency req/ack handshake.
- Formats load data (byte/half/word, signed/unsigned) and generates store byte enables.
- Stalls the front of the pipeline while an access is outstanding.
- Presents reg_write_m, mem_to_reg_m, alu_out_m, read_data_m and write_reg_m to the write-back stage.

Parameters:
TIMEOUT_CYCLES, 256, wait cycles without ack before bus_err_m fires; 0 disables the timeout.
CNT_W, 9, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
reg_write_e  in  1  execute: writes a register
mem_to_reg_e  in  1  execute: load
mem_write_e  in  1  execute: store
mem_size_e  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
mem_unsigned_e  in  1  zero-extend loads
alu_out_e  in  32  address or ALU result
write_data_e  in  32  store data (unaligned, low bits)
write_reg_e  in  5  destination register
dmem_req  out  1  access request
dmem_we  out  1  write
dmem_addr  out  32  word address; alu_out[31:2] followed by 2'b00
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data, valid with ack
dmem_ack  in  1  access complete
stall_m  out  1  hold IF/ID/EX and the M register
reg_write_m  out  1  to write-back
mem_to_reg_m  out  1  to write-back
alu_out_m  out  32  to write-back
read_data_m  out  32  formatted load data
write_reg_m  out  5  to write-back
addr_err_m  out  1  misaligned access in M
bus_err_m  out  1  timeout pulse

Behaviour:
- M register: loads all *_e inputs on the clock edge when stall_m=0; holds when stall_m=1.
- Reset: clears all M register fields, FSM to IDLE, counter to 0. Consequently reg_write_m=0, mem_to_reg_m=0, alu_out_m=0, write_reg_m=0, dmem_req=0, stall_m=0, addr_err_m=0, bus_err_m=0.
- Misaligned access:
  - Half with addr[0]=1, or word with addr[1:0]!=0.
  - Sets addr_err_m=1 (combinational, while in M).
  - No dmem_req is issued.
  - reg_write_m is forced to 0.
- mem_op = (mem_to_reg | mem_write) & ~misaligned.
- FSM:
  - IDLE: dmem_req = mem_op. If ack is high in the same cycle, the access completes with zero wait and the state stays IDLE. If ack is low, go to WAIT and set the counter to 1.
  - WAIT: dmem_req = 1. On ack, return to IDLE. Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), pulse bus_err_m for one cycle, return to IDLE and treat the access as complete (loads return 0).
- Bus stability: dmem_addr, dmem_we, dmem_be and dmem_wdata are stable from the first req cycle until ack.
- stall_m = dmem_req & ~dmem_ack & ~timeout_hit.
- Timing of results:
  - reg_write_m = reg_write_q & ~stall_m & ~misaligned. This inserts a bubble into write-back during waits.
  - read_data_m is combinational from dmem_rdata in the ack cycle and is sampled by write-back at that edge.
  - Load latency: result reaches write-back the edge after ack.
- Store byte enables:
  - byte: 0001 shifted left by addr[1:0].
  - half: 0011 for addr[1]=0, 1100 for addr[1]=1.
  - word: 1111.
- Store data lanes:
  - byte: {4{wd[7:0]}}.
  - half: {2{wd[15:0]}}.
  - word: wd.
- Load formatting: select the byte lane by addr[1:0] or the half lane by addr[1], then sign- or zero-extend per mem_unsigned. For non-load instructions read_data_m is 0.
- Reset during WAIT: drop dmem_req the next cycle, discard the instruction, go to IDLE. The memory side must tolerate an abandoned request.

Decomposition:
- Package mem_pkg:
  - mem_size_t enum: MEM_B, MEM_H, MEM_W.
  - mem_state_t enum: IDLE, WAIT.
  - constant MEM_SIZE_RSVD.
- Sub-module mem_lane_fmt (combinational): store byte enables and lane replication, load extraction and extension, misalignment detect.

Test Plan:
- lw, alu_out_e=0x100, zero-wait ack, rdata=0xDEADBEEF -> stall_m never 1; dmem_be=1111; read_data_m=0xDEADBEEF; reg_write_m=1 in the ack cycle.
- lb signed, addr=0x103, rdata=0x80112233, ack after 3 cycles -> stall_m=1 for 3 cycles; reg_write_m=0 during the stall; read_data_m=0xFFFFFF80.
- lhu, addr=0x102, rdata=0x9ABC1234 -> read_data_m=0x00009ABC; sh, addr=0x102, wd=0x0000BEEF -> be=1100, wdata=0xBEEFBEEF.
- lw at addr=0x101 -> addr_err_m=1, dmem_req=0, reg_write_m=0, no stall.
- TIMEOUT_CYCLES=4, no ack -> bus_err_m pulses once at cycle 4; stall_m released; read_data_m=0.
- rst asserted in the 2nd WAIT cycle -> dmem_req=0 and all outputs 0 the next cycle; the next lw, issued after rst deasserts, completes normally.
